ir_car_select_sync: RTL

Registered, debounced successor to the combinational car selector in the IR driver. Slide-switch inputs are synchronised into CLK and debounced. A new car choice is committed only while the IR packet generator reports an inter-packet gap, so a transmitted packet never mixes two cars' carrier/timing settings. Sits between the board switches and the IR packet generator; drives the selection LEDs.

---
 rtl/ir_car_select_sync_pkg.sv | 25 ++
 rtl/ir_car_select_sync_sync_debounce.sv | 24 ++
 rtl/ir_car_select_sync.sv | 111 +++++++++++
 3 files changed

// File: rtl/ir_car_select_sync_pkg.sv
// Shared IR car constants: per-car carrier/timing settings, lookup table and selector state type.
package ir_car_select_sync_pkg;

  localparam int unsigned CAR_COUNT = 4;

  typedef struct packed {
    logic [15:0] carrier_div;   // CLK cycles per IR carrier period
    logic [7:0]  header_len;    // header mark length in carrier periods
    logic [7:0]  bit_len;       // data bit length in carrier periods
  } CarSettings;

  localparam CarSettings BLUE_PARAMS   = '{carrier_div: 16'd2632, header_len: 8'd40, bit_len: 8'd10};
  localparam CarSettings YELLOW_PARAMS = '{carrier_div: 16'd2500, header_len: 8'd48, bit_len: 8'd12};
  localparam CarSettings GREEN_PARAMS  = '{carrier_div: 16'd2778, header_len: 8'd36, bit_len: 8'd9};
  localparam CarSettings RED_PARAMS    = '{carrier_div: 16'd1786, header_len: 8'd32, bit_len: 8'd8};

  localparam CarSettings CAR_PARAMS [CAR_COUNT] = '{BLUE_PARAMS, YELLOW_PARAMS, GREEN_PARAMS, RED_PARAMS};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PENDING
  } car_sel_state_t;

endpackage

// File: rtl/ir_car_select_sync_sync_debounce.sv
// Multi-flop synchroniser bringing the asynchronous slide switches into the CLK domain.
module ir_car_select_sync_sync_debounce #(
  parameter int unsigned WIDTH       = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], raw};
    end
  end

  assign synced = stages[SYNC_STAGES-1];

endmodule

// File: rtl/ir_car_select_sync.sv
// Synchronised, debounced car selector; commits a new car only during an IR inter-packet gap.
// Optional: define IR_CAR_SELECT_BLINK_EN to blink the pending candidate on LEDS.
module ir_car_select_sync #(
  parameter int unsigned CAR_COUNT       = ir_car_select_sync_pkg::CAR_COUNT,
  parameter int unsigned IDX_W           = $clog2(CAR_COUNT),
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [IDX_W-1:0]                  SWITCHES,
  input  logic                              PACKET_IDLE,
  output ir_car_select_sync_pkg::CarSettings SELECTED_CAR,
  output logic [IDX_W-1:0]                  CAR_INDEX,
  output logic                              CHANGE_PENDING,
  output logic [IDX_W-1:0]                  LEDS
);

  import ir_car_select_sync_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LIM_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [LIM_W-1:0] CAR_LIMIT = LIM_W'(CAR_COUNT);

  logic [IDX_W-1:0] sw_s;
  logic [IDX_W-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic             in_range;
  car_sel_state_t   state;

  ir_car_select_sync_sync_debounce #(
    .WIDTH       (IDX_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_debounce (
    .clk    (CLK),
    .rst    (RESET),
    .raw    (SWITCHES),
    .synced (sw_s)
  );

  assign in_range       = ({1'b0, sw_s} < CAR_LIMIT);
  assign CHANGE_PENDING = (state == ST_PENDING);

  // Selection FSM; commit on PACKET_IDLE has priority over any switch movement while pending.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_IDLE;
      cand         <= '0;
      cnt          <= '0;
      CAR_INDEX    <= '0;
      SELECTED_CAR <= CAR_PARAMS[0];
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_range && (sw_s != CAR_INDEX)) begin
            cand  <= sw_s;
            cnt   <= '0;
            state <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (sw_s != cand) begin
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= ST_PENDING;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_PENDING: begin
          if (PACKET_IDLE) begin
            CAR_INDEX    <= cand;
            SELECTED_CAR <= CAR_PARAMS[cand];
            state        <= ST_IDLE;
          end else if (sw_s == CAR_INDEX) begin
            state <= ST_IDLE;
          end else if ((sw_s != cand) && in_range) begin
            cand  <= sw_s;
            cnt   <= '0;
            state <= ST_DEBOUNCE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IR_CAR_SELECT_BLINK_EN
  logic [23:0] blink_cnt;

  // Pending candidate blinks against blank; otherwise the committed car is shown.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      blink_cnt <= '0;
      LEDS      <= '0;
    end else begin
      blink_cnt <= blink_cnt + 24'd1;
      if (state == ST_PENDING) begin
        LEDS <= blink_cnt[23] ? '0 : cand;
      end else begin
        LEDS <= CAR_INDEX;
      end
    end
  end
`else
  assign LEDS = CAR_INDEX;
`endif

endmodule
